// File: rtl/if_id_stage.sv
// ============================================================================
// Module   : if_id_stage
// Purpose  : PC register, instruction fetch and IF/ID pipeline register with
//            RUN/HALTED control, branch flush and load-use stall.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_id_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter logic [3:0]  HALT_OP   = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] branch_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] IFID_instr,
    output logic [15:0] IFID_pc_plus2,
    output logic        IFID_valid,
    output logic [3:0]  IFID_Rs,
    output logic [3:0]  IFID_Rt,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [15:0] r_instr;
    logic [15:0] w_instr_nxt;
    logic [15:0] r_pc2;
    logic [15:0] w_pc2_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic [15:0] r_count;
    logic [15:0] w_count_nxt;
    logic [15:0] w_pc_plus2;
    logic        w_is_halt;

    assign w_pc_plus2 = r_pc + 16'd2;
    assign w_is_halt  = (imem_data[15:12] == HALT_OP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_pc2   <= 16'h0000;
            r_valid <= 1'b0;
            r_count <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_pc2   <= w_pc2_nxt;
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Priority: flush > stall > HALTED > RUN; every register holds by default.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_pc2_nxt   = r_pc2;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count;
        if (flush) begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = branch_target;
            w_instr_nxt = NOP_INSTR;
            w_pc2_nxt   = 16'h0000;
            w_valid_nxt = 1'b0;
        end else if (!stall) begin
            case (r_state)
                ST_HALTED: begin
                    w_instr_nxt = NOP_INSTR;
                    w_valid_nxt = 1'b0;
                end
                default: begin
                    w_instr_nxt = imem_data;
                    w_pc2_nxt   = w_pc_plus2;
                    w_valid_nxt = 1'b1;
                    if (r_count != 16'hFFFF) begin
                        w_count_nxt = r_count + 16'd1;
                    end
                    // A fetched HLT parks the PC on itself.
                    if (w_is_halt) begin
                        w_state_nxt = ST_HALTED;
                    end else begin
                        w_pc_nxt = w_pc_plus2;
                    end
                end
            endcase
        end
    end

    assign imem_addr     = r_pc;
    assign IFID_instr    = r_instr;
    assign IFID_pc_plus2 = r_pc2;
    assign IFID_valid    = r_valid;
    assign IFID_Rs       = r_instr[7:4];
    assign IFID_Rt       = r_instr[3:0];
    assign halted        = (r_state == ST_HALTED);
    assign fetch_count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// ============================================================================
// Module   : tb_if_id_stage
// Purpose  : Self-checking bench for if_id_stage against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_id_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] IFID_instr;
    logic [15:0] IFID_pc_plus2;
    logic        IFID_valid;
    logic [3:0]  IFID_Rs;
    logic [3:0]  IFID_Rt;
    logic        halted;
    logic [15:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model state
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pc2;
    logic        m_valid;
    logic        m_halted;
    logic [15:0] m_count;

    logic [73:0] act_v;
    logic [73:0] exp_v;

    if_id_stage #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000),
        .HALT_OP   (4'hF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .IFID_instr    (IFID_instr),
        .IFID_pc_plus2 (IFID_pc_plus2),
        .IFID_valid    (IFID_valid),
        .IFID_Rs       (IFID_Rs),
        .IFID_Rt       (IFID_Rt),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_step(input logic rn, input logic st, input logic fl,
                                       input logic [15:0] bt, input logic [15:0] d);
        if (!rn) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000;
            m_valid = 1'b0; m_halted = 1'b0; m_count = 16'h0000;
        end else if (fl) begin
            m_pc = bt; m_instr = 16'h0000; m_pc2 = 16'h0000;
            m_valid = 1'b0; m_halted = 1'b0;
        end else if (st) begin
            // everything holds
        end else if (m_halted) begin
            m_instr = 16'h0000; m_valid = 1'b0;
        end else begin
            m_instr = d;
            m_pc2   = m_pc + 16'd2;
            m_valid = 1'b1;
            if (m_count < 16'hFFFF) m_count = m_count + 16'd1;
            if (d[15:12] == 4'hF) m_halted = 1'b1;
            else m_pc = m_pc + 16'd2;
        end
    endfunction

    function automatic logic [73:0] pack_exp();
        return {m_pc, m_instr, m_pc2, m_valid, m_halted, m_count, m_instr[7:4], m_instr[3:0]};
    endfunction

    function automatic logic [73:0] pack_act();
        return {imem_addr, IFID_instr, IFID_pc_plus2, IFID_valid, halted, fetch_count, IFID_Rs, IFID_Rt};
    endfunction

    // Drive one clock cycle's inputs, step both DUT and model, settle past the edge.
    task automatic cycle(input logic rn, input logic st, input logic fl,
                         input logic [15:0] bt, input logic [15:0] d);
        rst_n = rn; stall = st; flush = fl; branch_target = bt; imem_data = d;
        @(posedge clk);
        model_step(rn, st, fl, bt, d);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b1, 1'b1, 16'h1234, 16'hF000);
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1123);
        act_v = pack_act(); exp_v = pack_exp(); n_checks++;
        if (act_v !== exp_v) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", act_v, exp_v);
        end
        n_checks++;
        if ({imem_addr, IFID_valid, halted, fetch_count} !== {16'h0000, 1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_const: pc=%h valid=%b halted=%b cnt=%h expected 0000/0/0/0000",
                     imem_addr, IFID_valid, halted, fetch_count);
        end
    endtask

    task automatic test_sequential();
        logic [15:0] prog [3];
        prog[0] = 16'h1123; prog[1] = 16'h2456; prog[2] = 16'h3789;
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 16'h0000, prog[i]);
            act_v = pack_act(); exp_v = pack_exp(); n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL seq_step%0d: got %h expected %h", i, act_v, exp_v);
            end
        end
        n_checks++;
        if ({imem_addr, IFID_instr, IFID_pc_plus2, IFID_Rs, IFID_Rt, fetch_count} !==
            {16'h0006, 16'h3789, 16'h0006, 4'h8, 4'h9, 16'h0003}) begin
            n_fail++;
            $display("FAIL seq_final: pc=%h instr=%h pc2=%h rs=%h rt=%h cnt=%h expected 0006 3789 0006 8 9 0003",
                     imem_addr, IFID_instr, IFID_pc_plus2, IFID_Rs, IFID_Rt, fetch_count);
        end
    endtask

    task automatic test_stall();
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h1111);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h2222);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 16'h0000, 16'h3333);
            n_checks++;
            if ({imem_addr, IFID_instr, fetch_count, IFID_valid} !== {16'h0004, 16'h2222, 16'h0002, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: pc=%h instr=%h cnt=%h valid=%b expected 0004 2222 0002 1",
                         i, imem_addr, IFID_instr, fetch_count, IFID_valid);
            end
        end
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h3333);
        act_v = pack_act(); exp_v = pack_exp(); n_checks++;
        if (act_v !== exp_v || IFID_pc_plus2 !== 16'h0006) begin
            n_fail++; $display("FAIL stall_release: got %h expected %h", act_v, exp_v);
        end
    endtask

    task automatic test_flush_stall();
        cycle(1'b1, 1'b1, 1'b1, 16'h0040, 16'h4444);
        act_v = pack_act(); exp_v = pack_exp(); n_checks++;
        if (act_v !== exp_v || {imem_addr, IFID_valid, IFID_instr} !== {16'h0040, 1'b0, 16'h0000}) begin
            n_fail++; $display("FAIL flush_stall: got %h expected %h", act_v, exp_v);
        end
    endtask

    task automatic test_halt();
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h5010 + 16'(i));
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'hF000);
        n_checks++;
        if ({IFID_instr, IFID_valid, halted, imem_addr} !== {16'hF000, 1'b1, 1'b1, 16'h000A}) begin
            n_fail++;
            $display("FAIL halt_latch: instr=%h valid=%b halted=%b pc=%h expected F000 1 1 000A",
                     IFID_instr, IFID_valid, halted, imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h6666);
            act_v = pack_act(); exp_v = pack_exp(); n_checks++;
            if (act_v !== exp_v || {IFID_instr, IFID_valid, imem_addr} !== {16'h0000, 1'b0, 16'h000A}) begin
                n_fail++; $display("FAIL halt_bubble%0d: got %h expected %h", i, act_v, exp_v);
            end
        end
        cycle(1'b1, 1'b0, 1'b1, 16'h0020, 16'h6666);
        n_checks++;
        if ({halted, imem_addr, IFID_valid} !== {1'b0, 16'h0020, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_flush: halted=%b pc=%h valid=%b expected 0 0020 0", halted, imem_addr, IFID_valid);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 1'b0, 1'b1, 16'hFFFE, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h7001);
        act_v = pack_act(); exp_v = pack_exp(); n_checks++;
        if (act_v !== exp_v || {imem_addr, IFID_pc_plus2} !== {16'h0000, 16'h0000}) begin
            n_fail++; $display("FAIL pc_wrap: got %h expected %h", act_v, exp_v);
        end
    endtask

    task automatic test_saturation();
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 65535; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h1000);
        n_checks++;
        if (fetch_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL count_reach_max: got %h expected FFFF", fetch_count);
        end
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h1000);
        act_v = pack_act(); exp_v = pack_exp(); n_checks++;
        if (act_v !== exp_v || fetch_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL count_saturate: got %h expected %h", act_v, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'hF123);
        cycle(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
        rst_n = 1'b0; stall = 1'b1;
        #2;
        act_v = pack_act(); exp_v = pack_exp(); n_checks++;
        if (act_v !== exp_v || halted !== 1'b1) begin
            n_fail++; $display("FAIL reset_async_glitch: got %h expected %h", act_v, exp_v);
        end
        @(posedge clk);
        model_step(1'b0, 1'b1, 1'b0, 16'h0000, imem_data);
        #1;
        n_checks++;
        if ({imem_addr, halted, fetch_count, IFID_valid} !== {16'h0000, 1'b0, 16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: pc=%h halted=%b cnt=%h valid=%b expected 0000 0 0000 0",
                     imem_addr, halted, fetch_count, IFID_valid);
        end
    endtask

    task automatic test_random();
        logic        rn, st, fl;
        logic [15:0] bt, d;
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(0, 39) != 0);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            bt = 16'($urandom) & 16'hFFFE;
            d  = 16'($urandom);
            if ($urandom_range(0, 5) == 0) d[15:12] = 4'hF;
            else if (d[15:12] == 4'hF) d[15:12] = 4'h2;
            cycle(rn, st, fl, bt, d);
            act_v = pack_act(); exp_v = pack_exp(); n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL random_%0d: got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        branch_target = 16'h0000; imem_data = 16'h0000;
        m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000;
        m_valid = 1'b0; m_halted = 1'b0; m_count = 16'h0000;
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_flush_stall();
        test_halt();
        test_wrap();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
